mux_pipe_n: RTL

MUX_PIPE_N -- requirements
Module: mux_pipe_n

---
 rtl/mux_pipe_pkg.sv | 14 +
 rtl/mux_pipe_fifo.sv | 59 +++++
 rtl/mux_pipe_n.sv | 98 +++++++++
 3 files changed

// File: rtl/mux_pipe_pkg.sv
// Shared definitions for the mux_pipe block.
//   sel_width()  : select-port width for a given lane count, never below 1.
//   ERR_CNT_W    : width of the saturating out-of-range select counter.
//   ERR_CNT_MAX  : saturation value of that counter.
package mux_pipe_pkg;

    localparam int unsigned ERR_CNT_W = 16;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_pipe_fifo.sv
// Small synchronous FIFO used as the mux_pipe output buffer.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (clears pointers/occupancy)
//   push, wdata   : write request and entry; ignored while full
//   pop           : read request; ignored while empty
//   rdata         : head entry (valid only while !empty)
//   full, empty   : registered occupancy flags
module mux_pipe_fifo #(
    parameter int unsigned WIDTH_E = 8,
    parameter int unsigned DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH_E-1:0] wdata,
    output logic [WIDTH_E-1:0] rdata,
    output logic               full,
    output logic               empty
);

    localparam int unsigned PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH_E-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mux_pipe_n.sv
// N-input lane multiplexer with a buffered valid/ready output.
// The selected WIDTH-bit lane is computed at acceptance and queued together
// with the select value and an out-of-range flag.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_data              : N_IN packed lanes, lane k = in_data[k*WIDTH +: WIDTH]
//   in_sel, in_valid     : lane index and its qualifier
//   in_ready             : buffer can accept this cycle (registered state only)
//   out_data/sel/err     : head entry, zero while out_valid is low
//   out_valid, out_ready : output handshake
//   err_cnt              : saturating count of accepted out-of-range selects
module mux_pipe_n
    import mux_pipe_pkg::*;
#(
    parameter  int unsigned N_IN  = 64,
    parameter  int unsigned WIDTH = 1,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned SEL_W = sel_width(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    localparam int unsigned ENTRY_W = 1 + SEL_W + WIDTH;

    logic               alive;
    logic               full;
    logic               empty;
    logic               accept;
    logic               pop;
    logic [WIDTH-1:0]   sel_data;
    logic               sel_err;
    logic [ENTRY_W-1:0] head;

    // Low through reset, high from the first cycle after release; keeps
    // in_ready purely registered.
    always_ff @(posedge clk) begin
        if (rst) alive <= 1'b0;
        else     alive <= 1'b1;
    end

    assign in_ready  = alive && !full;
    assign accept    = in_valid && in_ready && !rst;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    // Lanes beyond N_IN never match, so out-of-range selects yield zero.
    always_comb begin
        sel_data = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (in_sel == SEL_W'(k)) sel_data = in_data[k*WIDTH +: WIDTH];
        end
    end

    assign sel_err = ({1'b0, in_sel} >= (SEL_W+1)'(N_IN));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (accept && sel_err && (err_cnt != ERR_CNT_MAX)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

    mux_pipe_fifo #(
        .WIDTH_E (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .wdata ({sel_err, in_sel, sel_data}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        out_data = '0;
        out_sel  = '0;
        out_err  = 1'b0;
        if (out_valid) begin
            {out_err, out_sel, out_data} = head;
        end
    end

endmodule
